// File: rtl/layer0_in_pkg.sv
// layer0_in_pkg
//   Shared definitions for the layer0 input assembler: the assembler FSM
//   state encoding and the quantizer code width.
package layer0_in_pkg;

  // Code bits per feature (a 3-threshold quantizer yields 0..3).
  localparam int LAYER0_QBITS = 2;
  localparam int CODE_W       = 2;

  typedef logic [CODE_W-1:0] code_t;

  // FILL: collecting samples of a frame; HOLD: complete frame on the output.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_t;

endpackage

// File: rtl/layer0_quantizer.sv
// layer0_quantizer
//   Combinational 3-threshold quantizer. Signed compare of a sample
//   against three ordered thresholds; code = number of thresholds the
//   sample is greater than or equal to (0..3).
// Ports:
//   sample                : signed readout sample
//   thr_lo/thr_mid/thr_hi : signed thresholds (thr_lo <= thr_mid <= thr_hi)
//   code                  : 2-bit quantized code
module layer0_quantizer
  import layer0_in_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] thr_lo,
  input  logic [SAMPLE_W-1:0] thr_mid,
  input  logic [SAMPLE_W-1:0] thr_hi,
  output code_t               code
);

  logic ge_lo;
  logic ge_mid;
  logic ge_hi;

  always_comb begin
    ge_lo  = $signed(sample) >= $signed(thr_lo);
    ge_mid = $signed(sample) >= $signed(thr_mid);
    ge_hi  = $signed(sample) >= $signed(thr_hi);
    code   = CODE_W'(ge_lo) + CODE_W'(ge_mid) + CODE_W'(ge_hi);
  end

endmodule

// File: rtl/layer0_input_assembler.sv
// layer0_input_assembler
//   Collects FEAT_COUNT quantized samples into one packed frame vector for
//   the layer0 neuron bank. Each accepted sample is quantized against the
//   thresholds present in its accept cycle and written to feature n, where n
//   is its position in the frame. s_sof on a mid-frame sample restarts the
//   frame at that sample and sets the sticky frame_err flag.
//
//   Optional feature: define LAYER0_IN_DBLBUF_EN to add a separate fill
//   buffer so a new frame can be collected while the previous one is held
//   on the output. Without it, s_ready is low while a frame is held.
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   s_valid/s_ready/s_data  : sample stream, s_sof marks feature 0
//   thr_lo/thr_mid/thr_hi   : signed quantizer thresholds
//   m_valid/m_ready/m_feat  : frame output, feature k at bits [2k+1:2k]
//   frame_err               : sticky, set on an s_sof mid-frame
module layer0_input_assembler
  import layer0_in_pkg::*;
#(
  parameter int FEAT_COUNT = 16,
  parameter int SAMPLE_W   = 12,
  parameter int QBITS      = LAYER0_QBITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [SAMPLE_W-1:0]         s_data,
  input  logic                        s_sof,
  input  logic [SAMPLE_W-1:0]         thr_lo,
  input  logic [SAMPLE_W-1:0]         thr_mid,
  input  logic [SAMPLE_W-1:0]         thr_hi,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [FEAT_COUNT*QBITS-1:0] m_feat,
  output logic                        frame_err
);

  localparam int CNT_W = $clog2(FEAT_COUNT);
  localparam int VEC_W = FEAT_COUNT * QBITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FEAT_COUNT - 1);

  asm_state_t       state;
  asm_state_t       state_next;
  logic             ready_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] wr_idx;
  logic [VEC_W-1:0] fill_q;
  logic [VEC_W-1:0] fill_next;
  logic             err_q;
  code_t            code;
  logic             accept;
  logic             restart;
  logic             fill_done;

`ifdef LAYER0_IN_DBLBUF_EN
  logic [VEC_W-1:0] out_q;
  logic [VEC_W-1:0] out_next;
  logic             pend_q;
  logic             pend_next;
  logic             load_out;
  logic             hold_release;
`endif

  layer0_quantizer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_quant (
    .sample  (s_data),
    .thr_lo  (thr_lo),
    .thr_mid (thr_mid),
    .thr_hi  (thr_hi),
    .code    (code)
  );

  // Fill buffer with the incoming code written into its slot. A mid-frame
  // s_sof redirects the write to feature 0.
  always_comb begin
    wr_idx    = restart ? '0 : cnt;
    fill_next = fill_q;
    for (int unsigned k = 0; k < FEAT_COUNT; k++) begin
      if (k == 32'(wr_idx)) begin
        fill_next[k*QBITS +: QBITS] = QBITS'(code);
      end
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (restart) begin
      cnt_next = CNT_W'(1);
    end else if (fill_done) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

`ifdef LAYER0_IN_DBLBUF_EN
  // Output register and fill buffer are independent. A completed fill goes
  // straight to the output when it is free or being released this cycle;
  // otherwise it waits in the fill buffer (pend_q) with s_ready low.
  always_comb begin
    state_next   = state;
    s_ready      = ready_en && !pend_q;
    accept       = s_valid && s_ready;
    restart      = accept && s_sof && (cnt != '0);
    fill_done    = accept && !restart && (cnt == LAST);
    hold_release = (state == HOLD) && m_ready;
    load_out     = 1'b0;
    pend_next    = pend_q;
    out_next     = fill_done ? fill_next : fill_q;
    if (fill_done) begin
      if ((state == FILL) || hold_release) begin
        load_out   = 1'b1;
        state_next = HOLD;
      end else begin
        pend_next  = 1'b1;
      end
    end else if (hold_release) begin
      if (pend_q) begin
        load_out   = 1'b1;
        pend_next  = 1'b0;
      end else begin
        state_next = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      ready_en <= 1'b0;
      cnt      <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
      out_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      cnt      <= cnt_next;
      pend_q   <= pend_next;
      if (accept) begin
        fill_q <= fill_next;
      end
      if (restart) begin
        err_q  <= 1'b1;
      end
      if (load_out) begin
        out_q  <= out_next;
      end
    end
  end

  assign m_feat = out_q;
`else
  // Single buffer: the fill buffer doubles as the output register, so
  // sampling stops while a frame is held.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    if (state == FILL) begin
      s_ready = ready_en;
    end else if (m_ready) begin
      state_next = FILL;
    end
    accept    = s_valid && s_ready;
    restart   = accept && s_sof && (cnt != '0);
    fill_done = accept && !restart && (cnt == LAST);
    if (fill_done) begin
      state_next = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      ready_en <= 1'b0;
      cnt      <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      cnt      <= cnt_next;
      if (accept) begin
        fill_q <= fill_next;
      end
      if (restart) begin
        err_q  <= 1'b1;
      end
    end
  end

  assign m_feat = fill_q;
`endif

  assign m_valid   = (state == HOLD);
  assign frame_err = err_q;

endmodule
